calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: key_valid  in  1 / tecla  in  4 / key_ready  out  1  key-event handshake, accepted when key_valid && key_ready.
REQ-004 SHALL have ports: alu_start  out  1 / alu_subtract  out  1 / alu_a  out  8 / alu_b  out  8  ALU command.
REQ-005 SHALL have ports: alu_done  in  1 / alu_result  in  8 / alu_overflow  in  1  ALU response, valid in the alu_done cycle.
REQ-006 SHALL have ports: regadress  out  4 / regwrite  out  1 / regread  out  1 / regstore  out  8 / regload  in  8  register-file access; regload valid one cycle after regread.
REQ-007 SHALL have ports: A  out  8 / B  out  8  two-deep operand stack, B = top, signed two's complement / err  out  1  error indicator.
REQ-008 SHALL have parameter ALU_TIMEOUT, default 16, meaning the maximum number of cycles spent in ALU_WAIT.

Function
REQ-009 SHALL implement states IDLE, ALU_WAIT, REG_WRITE, REG_READ, ERROR.
REQ-010 SHALL drive key_ready=1 in IDLE and ERROR only, and 0 in all other states.
REQ-011 SHALL keep an internal fresh flag: while fresh=1, a digit key (0000-1001) sets B={0000,tecla} and clears fresh.
REQ-012 SHALL handle a digit key with fresh=0 as B*10+digit, computed at >=12 bits width; if the result is >127, go to ERROR, else B gets the result; the state stays IDLE.
REQ-013 SHALL handle key 1110 (enter) as A<=B, fresh<=1, in a single cycle.
REQ-014 SHALL handle keys 1010 (add) and 1011 (sub) as a one-cycle alu_start pulse with alu_a=A, alu_b=B, alu_subtract=tecla[0], then enter ALU_WAIT.
REQ-015 SHALL hold alu_a, alu_b and alu_subtract stable from the alu_start cycle until alu_done.
REQ-016 SHALL, in ALU_WAIT on alu_done with alu_overflow=0, set B<=alu_result, A<=0, fresh<=1, and return to IDLE.
REQ-017 SHALL, in ALU_WAIT on alu_done with alu_overflow=1, go to ERROR.
REQ-018 SHALL go to ERROR if alu_done has not arrived within ALU_TIMEOUT cycles of alu_start; alu_done in the same cycle as expiry wins.
REQ-019 SHALL treat key 1100 (store) as an address error if B[7]=1 or B>9 (go to ERROR); otherwise go to REG_WRITE.
REQ-020 SHALL in REG_WRITE assert regwrite=1 for exactly one cycle with regadress=B[3:0] and regstore=A, then set fresh<=1 and return to IDLE.
REQ-021 SHALL treat key 1101 (load) with the same address check as store; if valid, assert regread=1 for one cycle with regadress=B[3:0] and go to REG_READ.
REQ-022 SHALL in REG_READ capture B<=regload, set fresh<=1, and return to IDLE.
REQ-023 SHALL on entering ERROR set A<=8'h7F, B<=8'h7F, err<=1.
REQ-024 SHALL in ERROR ignore all keys except 1111.
REQ-025 SHALL handle key 1111 (clear), in any accepting state, as A<=0, B<=0, err<=0, fresh<=1, go to IDLE.
REQ-026 SHALL hold alu_start, regwrite and regread at 0 in every cycle not listed above.
REQ-027 SHALL hold regadress and regstore at their last values when idle.
REQ-028 SHALL ignore key_valid while key_ready=0; no queuing of keys.

Reset
REQ-029 SHALL, with reset high at a clock edge, force the state to IDLE and A=B=0, err=0, fresh=1, alu_start=regwrite=regread=0, alu_a=alu_b=0, alu_subtract=0, regadress=0, regstore=0.
REQ-030 SHALL let reset take priority over every other event, including mid-ALU_WAIT, REG_READ and ERROR; an alu_done arriving after reset SHALL be ignored.

Verification
REQ-031 SHALL cover: keys 1,2,enter,3,add, alu_done with result 15 -> B=15, A=0, exactly one alu_start pulse, alu_a=12, alu_b=3.
REQ-032 SHALL cover: keys 9,9,9 -> ERROR after the third digit, A=B=0x7F, err=1; then key 1111 -> A=B=0, err=0, IDLE.
REQ-033 SHALL cover: A=100, B=50, sub issued, alu_done with overflow=0 and result 50 -> B=50; a repeat with overflow=1 -> ERROR.
REQ-034 SHALL cover: A=42, B=7, store -> one regwrite cycle with regadress=7, regstore=42; then B=7, load with regload=42 -> B=42 two cycles after key acceptance.
REQ-035 SHALL cover: B=10 store -> ERROR with no regwrite; an add with no alu_done -> ERROR exactly ALU_TIMEOUT cycles after alu_start.
REQ-036 SHALL cover: reset asserted during ALU_WAIT, with alu_done in the following cycle -> IDLE, A=B=0, B unchanged by the stale result.

Source files
------------

// File: rtl/calc_sequencer.sv
// Key-driven calculator sequencer: builds decimal operands on a two-deep stack
// and hands add/sub to an external ALU and store/load to an external register file.
module calc_sequencer #(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] tecla,
    output logic       key_ready,
    output logic       alu_start,
    output logic       alu_subtract,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic       alu_overflow,
    output logic [3:0] regadress,
    output logic       regwrite,
    output logic       regread,
    output logic [7:0] regstore,
    input  logic [7:0] regload,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       err
);

    localparam int CW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ALU_WAIT, REG_WRITE, REG_READ, ERROR} state_t;

    state_t         state, stateNext;
    logic           fresh, freshNext;
    logic [7:0]     aNext, bNext;
    logic           errNext;
    logic           aluStartNext, aluSubNext;
    logic [7:0]     aluANext, aluBNext;
    logic           regWriteNext, regReadNext;
    logic [3:0]     regAdrNext;
    logic [7:0]     regStoreNext;
    logic [CW-1:0]  waitCnt, waitCntNext;
    logic           accept;
    logic           addrBad;
    logic [11:0]    accum;

    assign key_ready = (state == IDLE) || (state == ERROR);
    assign accept    = key_valid && key_ready;
    assign accum     = {4'd0, B} * 12'd10 + {8'd0, tecla};
    assign addrBad   = B[7] || (B > 8'd9);

    // Next-state and next-register logic; error entry loads the saturated display value.
    always_comb begin
        stateNext    = state;
        freshNext    = fresh;
        aNext        = A;
        bNext        = B;
        errNext      = err;
        aluStartNext = 1'b0;
        aluSubNext   = alu_subtract;
        aluANext     = alu_a;
        aluBNext     = alu_b;
        regWriteNext = 1'b0;
        regReadNext  = 1'b0;
        regAdrNext   = regadress;
        regStoreNext = regstore;
        waitCntNext  = waitCnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (tecla <= 4'd9) begin
                        if (fresh) begin
                            bNext     = {4'd0, tecla};
                            freshNext = 1'b0;
                        end else if (accum > 12'd127) begin
                            stateNext = ERROR;
                        end else begin
                            bNext = accum[7:0];
                        end
                    end else begin
                        case (tecla)
                            4'hA, 4'hB: begin
                                aluStartNext = 1'b1;
                                aluANext     = A;
                                aluBNext     = B;
                                aluSubNext   = tecla[0];
                                waitCntNext  = '0;
                                stateNext    = ALU_WAIT;
                            end
                            4'hC: begin
                                if (addrBad) begin
                                    stateNext = ERROR;
                                end else begin
                                    regWriteNext = 1'b1;
                                    regAdrNext   = B[3:0];
                                    regStoreNext = A;
                                    stateNext    = REG_WRITE;
                                end
                            end
                            4'hD: begin
                                if (addrBad) begin
                                    stateNext = ERROR;
                                end else begin
                                    regReadNext = 1'b1;
                                    regAdrNext  = B[3:0];
                                    stateNext   = REG_READ;
                                end
                            end
                            4'hE: begin
                                aNext     = B;
                                freshNext = 1'b1;
                            end
                            default: begin
                                aNext     = 8'd0;
                                bNext     = 8'd0;
                                errNext   = 1'b0;
                                freshNext = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ALU_WAIT: begin
                if (alu_done) begin
                    if (alu_overflow) begin
                        stateNext = ERROR;
                    end else begin
                        bNext     = alu_result;
                        aNext     = 8'd0;
                        freshNext = 1'b1;
                        stateNext = IDLE;
                    end
                end else if (waitCnt == CW'(ALU_TIMEOUT - 1)) begin
                    stateNext = ERROR;
                end else begin
                    waitCntNext = waitCnt + CW'(1);
                end
            end
            REG_WRITE: begin
                freshNext = 1'b1;
                stateNext = IDLE;
            end
            REG_READ: begin
                // The first REG_READ cycle carries the regread strobe; data arrives in the next.
                if (!regread) begin
                    bNext     = regload;
                    freshNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            ERROR: begin
                if (accept && tecla == 4'hF) begin
                    aNext     = 8'd0;
                    bNext     = 8'd0;
                    errNext   = 1'b0;
                    freshNext = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (stateNext == ERROR && state != ERROR) begin
            aNext   = 8'h7F;
            bNext   = 8'h7F;
            errNext = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            fresh        <= 1'b1;
            A            <= 8'd0;
            B            <= 8'd0;
            err          <= 1'b0;
            alu_start    <= 1'b0;
            alu_subtract <= 1'b0;
            alu_a        <= 8'd0;
            alu_b        <= 8'd0;
            regwrite     <= 1'b0;
            regread      <= 1'b0;
            regadress    <= 4'd0;
            regstore     <= 8'd0;
            waitCnt      <= '0;
        end else begin
            state        <= stateNext;
            fresh        <= freshNext;
            A            <= aNext;
            B            <= bNext;
            err          <= errNext;
            alu_start    <= aluStartNext;
            alu_subtract <= aluSubNext;
            alu_a        <= aluANext;
            alu_b        <= aluBNext;
            regwrite     <= regWriteNext;
            regread      <= regReadNext;
            regadress    <= regAdrNext;
            regstore     <= regStoreNext;
            waitCnt      <= waitCntNext;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random key streams
// against an arithmetic model of the calculator, with bench-side ALU and register file.
module tb_calc_sequencer;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] tecla;
    logic       key_ready;
    logic       alu_start;
    logic       alu_subtract;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic [3:0] regadress;
    logic       regwrite;
    logic       regread;
    logic [7:0] regstore;
    logic [7:0] regload;
    logic [7:0] A;
    logic [7:0] B;
    logic       err;

    int vectors = 0;
    int miscompares = 0;
    int startCount = 0;

    int mA, mB;
    bit mErr, mFresh;
    int refMem[16];
    logic [7:0] mem[16];

    calc_sequencer #(.ALU_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .tecla(tecla), .key_ready(key_ready),
        .alu_start(alu_start), .alu_subtract(alu_subtract), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .regadress(regadress), .regwrite(regwrite), .regread(regread),
        .regstore(regstore), .regload(regload),
        .A(A), .B(B), .err(err)
    );

    always #5 clk = ~clk;

    // Bench-side register file with one-cycle read latency, and an alu_start pulse counter.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17 + 3);
        end else begin
            if (regwrite) mem[regadress] <= regstore;
            if (regread) regload <= mem[regadress];
        end
        if (alu_start) startCount <= startCount + 1;
    end

    function automatic int u8(input int v);
        return v & 255;
    endfunction

    function automatic int s8(input int v);
        int w;
        w = v & 255;
        return (w > 127) ? w - 256 : w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mA = 0; mB = 0; mErr = 0; mFresh = 1;
        for (int i = 0; i < 16; i++) refMem[i] = s8(i * 17 + 3);
    endtask

    task automatic modelClear();
        mA = 0; mB = 0; mErr = 0; mFresh = 1;
    endtask

    task automatic enterError();
        mA = 127; mB = 127; mErr = 1;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".A"}, A, u8(mA));
        checkOutput({tag, ".B"}, B, u8(mB));
        checkOutput({tag, ".err"}, err, mErr);
        checkOutput({tag, ".ready"}, key_ready, 1);
    endtask

    task automatic doReset();
        reset = 1'b1; key_valid = 1'b0; alu_done = 1'b0; alu_overflow = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input logic [3:0] k);
        int n = 0;
        while (key_ready !== 1'b1 && n < 64) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        if (key_ready !== 1'b1) checkOutput("ready_wait", key_ready, 1);
        key_valid = 1'b1;
        tecla = k;
        @(posedge clk); @(negedge clk);
        key_valid = 1'b0;
        tecla = 4'($urandom);
    endtask

    task automatic doDigit(input int d);
        int v;
        applyStimulus(4'(d));
        if (mFresh) begin
            mB = d; mFresh = 0;
        end else begin
            v = mB * 10 + d;
            if (v > 127) enterError();
            else mB = v;
        end
        checkState("digit");
    endtask

    task automatic doSimple(input logic [3:0] k);
        applyStimulus(k);
        if (k == 4'hF) modelClear();
        else if (k == 4'hE && !mErr) begin mA = mB; mFresh = 1; end
        checkState(mErr ? "errkey" : "key");
    endtask

    task automatic doAlu(input logic [3:0] k, input int j, input bit forceOvf);
        int exact, res;
        bit ovf, done;
        applyStimulus(k);
        checkOutput("alu_start", alu_start, 1);
        checkOutput("alu_a", alu_a, u8(mA));
        checkOutput("alu_b", alu_b, u8(mB));
        checkOutput("alu_sub", alu_subtract, k[0]);
        exact = (k == 4'hA) ? mA + mB : mA - mB;
        ovf = forceOvf || exact < -128 || exact > 127;
        res = exact & 255;
        done = 0;
        for (int c = 0; c < T; c++) begin
            if (c > 0) begin
                checkOutput("alu_pulse", alu_start, 0);
                checkOutput("alu_a_hold", alu_a, u8(mA));
            end
            checkOutput("wait_ready", key_ready, 0);
            key_valid = 1'($urandom_range(0, 1));
            tecla = 4'($urandom);
            if (c == j) begin
                alu_done = 1'b1; alu_result = 8'(res); alu_overflow = ovf;
            end
            @(posedge clk); @(negedge clk);
            alu_done = 1'b0; alu_overflow = 1'b0; alu_result = 8'($urandom);
            if (c == j) begin
                done = 1;
                break;
            end
        end
        key_valid = 1'b0;
        if (!done || ovf) enterError();
        else begin mB = s8(res); mA = 0; mFresh = 1; end
        checkState("alu");
        checkOutput("alu_idle", alu_start, 0);
    endtask

    task automatic doStore();
        int adr;
        applyStimulus(4'hC);
        if (mB < 0 || mB > 9) begin
            checkOutput("store_bad_wr", regwrite, 0);
            enterError();
        end else begin
            adr = mB;
            checkOutput("regwrite", regwrite, 1);
            checkOutput("wr_adr", regadress, adr);
            checkOutput("regstore", regstore, u8(mA));
            refMem[adr] = mA;
            @(posedge clk); @(negedge clk);
            checkOutput("regwrite_off", regwrite, 0);
            checkOutput("adr_hold", regadress, adr);
            mFresh = 1;
        end
        checkState("store");
    endtask

    task automatic doLoad();
        int adr;
        applyStimulus(4'hD);
        if (mB < 0 || mB > 9) begin
            checkOutput("load_bad_rd", regread, 0);
            enterError();
        end else begin
            adr = mB;
            checkOutput("regread", regread, 1);
            checkOutput("rd_adr", regadress, adr);
            @(posedge clk); @(negedge clk);
            checkOutput("regread_off", regread, 0);
            checkOutput("load_B_early", B, u8(mB));
            @(posedge clk); @(negedge clk);
            mB = refMem[adr];
            mFresh = 1;
        end
        checkState("load");
    endtask

    task automatic doRandomAction();
        int r;
        if (mErr) begin
            doSimple(($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
            return;
        end
        r = $urandom_range(0, 99);
        if (r < 45) doDigit($urandom_range(0, 9));
        else if (r < 55) doSimple(4'hE);
        else if (r < 75) doAlu(($urandom_range(0, 1) == 1) ? 4'hB : 4'hA,
                               ($urandom_range(0, 9) == 0) ? T + 1 : $urandom_range(0, 6),
                               ($urandom_range(0, 15) == 0));
        else if (r < 83) doStore();
        else if (r < 91) doLoad();
        else doSimple(4'hF);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0;
        key_valid = 1'b0; tecla = 4'd0; alu_done = 1'b0; alu_result = 8'd0; alu_overflow = 1'b0;
        doReset();
        checkState("reset");
        checkOutput("rst_alu_start", alu_start, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_alu_sub", alu_subtract, 0);
        checkOutput("rst_regwrite", regwrite, 0);
        checkOutput("rst_regread", regread, 0);
        checkOutput("rst_regadress", regadress, 0);
        checkOutput("rst_regstore", regstore, 0);

        $display("[TB] 12 + 3");
        doDigit(1); doDigit(2); doSimple(4'hE); doDigit(3);
        s0 = startCount;
        doAlu(4'hA, 2, 0);
        checkOutput("sum_B", B, 15);
        checkOutput("pulse_count", startCount - s0, 1);

        $display("[TB] 999 overflow and clear");
        doDigit(9); doDigit(9);
        checkOutput("B_99", B, 99);
        doDigit(9);
        checkOutput("ovf_err", err, 1);
        doSimple(4'h3);
        doSimple(4'hF);
        checkOutput("clear_B", B, 0);

        $display("[TB] 100 - 50");
        doDigit(1); doDigit(0); doDigit(0); doSimple(4'hE); doDigit(5); doDigit(0);
        doAlu(4'hB, 1, 0);
        checkOutput("diff_B", B, 50);
        doDigit(1); doDigit(0); doDigit(0); doSimple(4'hE); doDigit(5); doDigit(0);
        doAlu(4'hB, 0, 1);
        checkOutput("sub_ovf_err", err, 1);
        doSimple(4'hF);

        $display("[TB] store and load");
        doDigit(4); doDigit(2); doSimple(4'hE); doDigit(7);
        doStore();
        doDigit(7);
        doLoad();
        checkOutput("load_B", B, 42);

        $display("[TB] bad address and timeout");
        doDigit(1); doDigit(0);
        doStore();
        checkOutput("bad_adr_err", err, 1);
        doSimple(4'hF);
        doDigit(2); doSimple(4'hE); doDigit(3);
        doAlu(4'hA, T + 5, 0);
        checkOutput("timeout_err", err, 1);
        doSimple(4'hF);
        doDigit(2); doSimple(4'hE); doDigit(3);
        doAlu(4'hA, T - 1, 0);
        checkOutput("late_done_B", B, 5);

        $display("[TB] reset during ALU_WAIT");
        doDigit(6); doSimple(4'hE); doDigit(4);
        applyStimulus(4'hA);
        checkOutput("pre_rst_start", alu_start, 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        modelReset();
        alu_done = 1'b1; alu_result = 8'h55; alu_overflow = 1'b0;
        @(posedge clk); @(negedge clk);
        alu_done = 1'b0;
        checkState("rst_alu");
        checkOutput("rst_alu_a2", alu_a, 0);

        $display("[TB] reset during REG_READ and ERROR");
        doDigit(3);
        applyStimulus(4'hD);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(posedge clk); @(negedge clk);
        checkState("rst_read");
        checkOutput("rst_read_rd", regread, 0);
        doDigit(9); doDigit(9); doDigit(9);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkState("rst_err");

        $display("[TB] random key stream");
        for (int i = 0; i < 300; i++) doRandomAction();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
